// File: rtl/tokenflow_pkg.sv
// Shared definitions for the tokenflow receiver.
//   state_t      : handshake FSM states
//   W_DEFAULT    : default channel data width
//   SEQ_CNT_MAX  : saturation value of the 16-bit token counter
package tokenflow_pkg;

    typedef enum logic {
        WAIT_REQ = 1'b0,
        WAIT_RLS = 1'b1
    } state_t;

    localparam int          W_DEFAULT   = 15;
    localparam logic [15:0] SEQ_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/tokenflow_rx_if.sv
// Bundle of the receiver's channel, stream and status signals.
//   ch_req/ch_data/ch_ack : 4-phase bundled-data channel from the generator
//   out_valid/out_ready/out_data : ready/valid stream to on-chip logic
//   seq_err/seq_count     : checker status
// slave  : receiver side (tokenflow_rx)
// master : sender/consumer side
interface tokenflow_rx_if #(
    parameter int W = tokenflow_pkg::W_DEFAULT
);
    logic         ch_req;
    logic [W-1:0] ch_data;
    logic         ch_ack;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         seq_err;
    logic [15:0]  seq_count;

    modport slave (
        input  ch_req, ch_data, out_ready,
        output ch_ack, out_valid, out_data, seq_err, seq_count
    );

    modport master (
        output ch_req, ch_data, out_ready,
        input  ch_ack, out_valid, out_data, seq_err, seq_count
    );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous inputs, reset to 0.
//   clk, rst_n : clock and async active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronised output, STAGES cycles later
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] ff_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) ff_q[i] <= '0;
        end else begin
            ff_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) ff_q[i] <= ff_q[i-1];
        end
    end

    assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/tokenflow_rx.sv
// Clocked receiver for the asynchronous tokenflow generator.
// Terminates the 4-phase channel, buffers tokens in a FIFO, presents them
// as a ready/valid stream and checks them against k*(k+1).
//   clk, rst_n : clock and async active-low reset
//   rx         : tokenflow_rx_if.slave (channel, stream, checker status)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_REQ | ack low; capture on synchronised req high and FIFO not full
// WAIT_RLS | ack high; wait for synchronised req to drop
module tokenflow_rx
    import tokenflow_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    tokenflow_rx_if.slave  rx
);
    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);
    localparam logic [W-1:0] K_ONE   = W'(1);

    logic         req_s;
    state_t       state_q, state_d;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] exp_q, k_q;
    logic         seq_err_q;
    logic [15:0]  seq_cnt_q;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx.ch_req),
        .q_o   (req_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_REQ;
        else        state_q <= state_d;
    end

    // Full is taken from pre-edge occupancy, so a same-cycle pop never
    // frees room for a push; the stalled token is captured one edge later.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            WAIT_REQ: begin
                if (req_s && !full) begin
                    push    = 1'b1;
                    state_d = WAIT_RLS;
                end
            end
            WAIT_RLS: begin
                if (!req_s) state_d = WAIT_REQ;
            end
            default: state_d = WAIT_REQ;
        endcase
    end

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = !empty && rx.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx.ch_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= '0;
            k_q       <= '0;
            seq_err_q <= 1'b0;
            seq_cnt_q <= '0;
        end else if (push) begin
            if (rx.ch_data != exp_q) seq_err_q <= 1'b1;
            exp_q <= exp_q + ((k_q + K_ONE) << 1);
            k_q   <= k_q + K_ONE;
            if (seq_cnt_q != SEQ_CNT_MAX) seq_cnt_q <= seq_cnt_q + 16'd1;
        end
    end

    // Ack follows the state register, so async reset drops it at once.
    assign rx.ch_ack    = (state_q == WAIT_RLS);
    assign rx.out_valid = !empty;
    assign rx.out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign rx.seq_err   = seq_err_q;
    assign rx.seq_count = seq_cnt_q;
endmodule

// File: tb/tb_tokenflow_rx.sv
module tb_tokenflow_rx;
    logic clk;
    logic rst_n;

    int n_chk  = 0;
    int n_fail = 0;

    logic [14:0] popq [$];
    logic [14:0] exp_s [6] = '{15'd0, 15'd2, 15'd6, 15'd12, 15'd20, 15'd30};

    tokenflow_rx_if #(.W(15)) bus ();

    tokenflow_rx #(
        .W           (15),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) popq.push_back(bus.out_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.ch_req    = 1'b0;
        bus.ch_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        popq.delete();
    endtask

    task automatic raise_req(input logic [14:0] v);
        @(negedge clk);
        bus.ch_data = v;
        bus.ch_req  = 1'b1;
    endtask

    // Counts posedges until ack reaches lvl; -1 if the bound expires.
    task automatic wait_ack(input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ch_ack !== lvl && n < bound);
        if (bus.ch_ack !== lvl) n = -1;
    endtask

    task automatic send_token(input logic [14:0] v, output int nr, output int nf);
        raise_req(v);
        wait_ack(1'b1, 100, nr);
        @(negedge clk);
        bus.ch_req = 1'b0;
        wait_ack(1'b0, 100, nf);
    endtask

    task automatic check_queue(input string tag, input int len);
        chk({tag, "_len"}, popq.size(), len);
        for (int i = 0; i < len && i < popq.size(); i++)
            chk({tag, "_val"}, popq[i], exp_s[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nr, nf;
        logic seen_a, seen_v;

        // Reset state and idle channel
        apply_reset();
        chk("rst_ack", bus.ch_ack, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_err", bus.seq_err, 0);
        chk("rst_cnt", bus.seq_count, 0);
        seen_a = 0;
        seen_v = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.ch_ack)    seen_a = 1;
            if (bus.out_valid) seen_v = 1;
        end
        chk("idle_ack", seen_a, 0);
        chk("idle_valid", seen_v, 0);

        // Single token with latency measurement
        raise_req(15'd0);
        wait_ack(1'b1, 100, nr);
        chk("single_ack_lat", nr, 3);
        chk("single_valid", bus.out_valid, 1);
        chk("single_data", bus.out_data, 0);
        chk("single_cnt", bus.seq_count, 1);
        chk("single_err", bus.seq_err, 0);
        @(negedge clk);
        bus.ch_req = 1'b0;
        wait_ack(1'b0, 100, nf);
        chk("single_rls_lat", nf, 3);

        // Streaming with consumer always ready
        apply_reset();
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_token(exp_s[i], nr, nf);
            chk("stream_ack_lat", nr, 3);
        end
        repeat (4) @(posedge clk);
        #1;
        check_queue("stream", 6);
        chk("stream_cnt", bus.seq_count, 6);
        chk("stream_err", bus.seq_err, 0);

        // Backpressure: fill FIFO, 5th token stalls
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            send_token(exp_s[i], nr, nf);
            chk("fill_ack_lat", nr, 3);
        end
        raise_req(exp_s[4]);
        seen_a = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.ch_ack) seen_a = 1;
        end
        chk("stall_no_ack", seen_a, 0);
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_cnt", bus.seq_count, 4);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("pop_edge_ack", bus.ch_ack, 0);
        @(posedge clk);
        #1;
        chk("after_pop_ack", bus.ch_ack, 1);
        @(negedge clk);
        bus.ch_req = 1'b0;
        wait_ack(1'b0, 100, nf);
        chk("stall_rls_lat", nf, 3);
        @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_queue("drain", 5);
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_cnt", bus.seq_count, 5);
        chk("drain_err", bus.seq_err, 0);

        // Sequence error is sticky
        apply_reset();
        @(negedge clk);
        bus.out_ready = 1'b1;
        send_token(15'd0, nr, nf);
        send_token(15'd2, nr, nf);
        chk("err_before", bus.seq_err, 0);
        raise_req(15'd7);
        wait_ack(1'b1, 100, nr);
        chk("err_set", bus.seq_err, 1);
        @(negedge clk);
        bus.ch_req = 1'b0;
        wait_ack(1'b0, 100, nf);
        send_token(15'd12, nr, nf);
        chk("err_sticky1", bus.seq_err, 1);
        send_token(15'd20, nr, nf);
        chk("err_sticky2", bus.seq_err, 1);
        send_token(15'd30, nr, nf);
        chk("err_sticky3", bus.seq_err, 1);
        chk("err_cnt", bus.seq_count, 6);

        // Async reset mid-handshake
        apply_reset();
        raise_req(15'd0);
        wait_ack(1'b1, 100, nr);
        chk("mid_ack_high", bus.ch_ack, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ack", bus.ch_ack, 0);
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_cnt", bus.seq_count, 0);
        bus.ch_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        popq.delete();
        send_token(15'd0, nr, nf);
        chk("post_rst_ack_lat", nr, 3);
        chk("post_rst_cnt", bus.seq_count, 1);
        chk("post_rst_err", bus.seq_err, 0);
        chk("post_rst_data", bus.out_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
